// File: rtl/cv32e41p_apu_arbiter_if.sv
// Bundle of the core-side apu_* signals and the shared-FPU port.
// The arbiter connects through the slave modport. The surrounding
// environment (the cores plus the FPU) connects through the master modport.
interface cv32e41p_apu_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int NARGS    = 3,
    parameter int WOP      = 6,
    parameter int NDSFLAGS = 15,
    parameter int NUSFLAGS = 5
);
    logic [NUM_REQ-1:0]          req_i;
    logic [NUM_REQ-1:0]          gnt_o;
    logic [NUM_REQ*NARGS*32-1:0] operands_i;
    logic [NUM_REQ*WOP-1:0]      op_i;
    logic [NUM_REQ*NDSFLAGS-1:0] flags_i;
    logic [NUM_REQ-1:0]          rvalid_o;
    logic [31:0]                 result_o;
    logic [NUSFLAGS-1:0]         flags_o;

    logic                        fpu_req_o;
    logic                        fpu_gnt_i;
    logic [NARGS*32-1:0]         fpu_operands_o;
    logic [WOP-1:0]              fpu_op_o;
    logic [NDSFLAGS-1:0]         fpu_flags_o;
    logic                        fpu_rvalid_i;
    logic [31:0]                 fpu_result_i;
    logic [NUSFLAGS-1:0]         fpu_flags_i;

    modport slave (
        input  req_i, operands_i, op_i, flags_i,
        input  fpu_gnt_i, fpu_rvalid_i, fpu_result_i, fpu_flags_i,
        output gnt_o, rvalid_o, result_o, flags_o,
        output fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o
    );

    modport master (
        output req_i, operands_i, op_i, flags_i,
        output fpu_gnt_i, fpu_rvalid_i, fpu_result_i, fpu_flags_i,
        input  gnt_o, rvalid_o, result_o, flags_o,
        input  fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o
    );
endinterface

// File: rtl/cv32e41p_apu_arbiter.sv
// Shares one APU/FPU between NUM_REQ cores.
// Requests are picked round-robin. A pick that the FPU has not granted yet
// is locked until it is granted.
// Responses come back in issue order. A FIFO of requester IDs routes each
// response to the core that issued it. DEPTH must be a power of 2 and >= 2.
module cv32e41p_apu_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int NARGS    = 3,
    parameter int WOP      = 6,
    parameter int NDSFLAGS = 15,
    parameter int NUSFLAGS = 5,
    parameter int DEPTH    = 4,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    cv32e41p_apu_arbiter_if.slave        bus,
    output logic [CW-1:0]                outstanding_o,
    output logic                         err_o
);
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(DEPTH);

    logic [SW-1:0] rr_q, sel_q, sel, rr_next;
    logic          lock_q, found;
    logic [SW-1:0] fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, fpu_req, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Pick the requester: the held one while locked, else first from rr_q
    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        if (lock_q) begin
            sel = sel_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && bus.req_i[(int'(rr_q) + k) % NUM_REQ]) begin
                    sel   = SW'((int'(rr_q) + k) % NUM_REQ);
                    found = 1'b1;
                end
            end
        end
    end

    assign rr_next = (sel == SW'(NUM_REQ - 1)) ? '0 : sel + SW'(1);

    // A full ID FIFO blocks new issue. Reset forces the request low.
    assign fpu_req = rst_ni & (|bus.req_i) & ~full;
    assign push    = fpu_req & bus.fpu_gnt_i;
    assign pop     = rst_ni & bus.fpu_rvalid_i & ~empty;

    assign bus.fpu_req_o      = fpu_req;
    assign bus.fpu_operands_o = bus.operands_i[int'(sel)*NARGS*32 +: NARGS*32];
    assign bus.fpu_op_o       = bus.op_i[int'(sel)*WOP +: WOP];
    assign bus.fpu_flags_o    = bus.flags_i[int'(sel)*NDSFLAGS +: NDSFLAGS];
    assign bus.result_o       = bus.fpu_result_i;
    assign bus.flags_o        = bus.fpu_flags_i;
    assign outstanding_o      = count_q;

    // Per-core grant: only the selected core sees the FPU grant
    always_comb begin
        bus.gnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.gnt_o[i] = push & (sel == SW'(i));
        end
    end

    // Route a response to the core at the FIFO head
    always_comb begin
        bus.rvalid_o = '0;
        if (pop) begin
            bus.rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    // Arbitration state: round-robin pointer and the lock on an ungranted pick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            sel_q  <= '0;
            lock_q <= 1'b0;
        end else if (push) begin
            rr_q   <= rr_next;
            lock_q <= 1'b0;
        end else if (fpu_req) begin
            sel_q  <= sel;
            lock_q <= 1'b1;
        end
    end

    // ID FIFO: pointers wrap naturally. The count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                fifo_q[d] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky flag: the FPU returned a response nobody was waiting for
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (bus.fpu_rvalid_i && empty) begin
            err_o <= 1'b1;
        end
    end
endmodule
